// File: rtl/nvme_ss_pkg.sv
// Shared types and constants for the sideband ID/status frame shifter.
package nvme_ss_pkg;

    // Shifter sequencing: parallel load, serial shift, wait for host re-arm
    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } ss_state_t;

    // Default sync header (sent MSB-first) and line level between frames
    localparam int unsigned DEF_HDR_VAL    = 32'b1010;
    localparam logic        DEF_IDLE_LEVEL = 1'b0;

    // Total serial frame length: header + payload + optional parity bit
    function automatic int frame_len(input int hdr_w, input int d, input int parity_en);
        return hdr_w + d + ((parity_en != 0) ? 1 : 0);
    endfunction

endpackage

// File: rtl/nvme_ss_rx_check.sv
// Receive side: deserialises the returned frame and checks header and parity.
// The shifter tells it when a bit ends (sample_en) and when the last bit of
// a frame ends (frame_end); the final bit is taken directly from dati so the
// result lands on the same edge that closes the frame.
module nvme_ss_rx_check
    import nvme_ss_pkg::*;
#(
    parameter int          D         = 4,
    parameter int          HDR_W     = 4,
    parameter int unsigned HDR_VAL   = DEF_HDR_VAL,
    parameter int          PARITY_EN = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         sample_en,
    input  logic         frame_end,
    input  logic         dati,
    output logic [D-1:0] rx_data,
    output logic         rx_valid,
    output logic         rx_hdr_ok,
    output logic         rx_par_ok
);

    localparam int          F        = frame_len(HDR_W, D, PARITY_EN);
    localparam int          PAR_W    = (PARITY_EN != 0) ? 1 : 0;
    localparam logic [31:0] HDR_BITS = 32'(HDR_VAL);

    logic [F-1:0] rx_sr;
    logic [F-1:0] rx_frame;
    logic [D-1:0] rx_payload;
    logic         hdr_match;
    logic         par_match;

    // The frame as it stands once the bit currently on the line is included
    assign rx_frame   = F'({rx_sr, dati});
    assign rx_payload = rx_frame[PAR_W +: D];

    generate
        if (HDR_W > 0) begin : g_hdr
            assign hdr_match = (rx_frame[F-1 -: HDR_W] == HDR_BITS[HDR_W-1:0]);
        end else begin : g_no_hdr
            assign hdr_match = 1'b1;
        end

        if (PARITY_EN != 0) begin : g_par
            assign par_match = ((^rx_payload) == rx_frame[0]);
        end else begin : g_no_par
            assign par_match = 1'b1;
        end
    endgenerate

    // Shift in returned bits and publish the checked payload at frame end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sr     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            rx_hdr_ok <= 1'b0;
            rx_par_ok <= 1'b0;
        end else begin
            rx_valid <= frame_end;
            if (sample_en) begin
                rx_sr <= rx_frame;
            end
            if (frame_end) begin
                rx_data   <= rx_payload;
                rx_hdr_ok <= hdr_match;
                rx_par_ok <= par_match;
            end
        end
    end

endmodule

// File: rtl/nvme_ss_frame_shifter.sv
// Framed ID/status serial shifter for the host sideband link.
// Loads NUM_CH x BITS_PER_CH strap/status bits, sends them MSB-first behind a
// sync header with optional even parity, and checks the frame returned on
// AROC_SS_DATI in lock-step. With CONTINUOUS set, frames repeat back-to-back
// (re-sampling ROC_ID at each frame boundary) until AROC_SS_LD_N drops.
module nvme_ss_frame_shifter
    import nvme_ss_pkg::*;
#(
    parameter int          NUM_CH      = 1,
    parameter int          BITS_PER_CH = 4,
    parameter int          HDR_W       = 4,
    parameter int unsigned HDR_VAL     = DEF_HDR_VAL,
    parameter int          PARITY_EN   = 1,
    parameter int          CONTINUOUS  = 0,
    parameter logic        IDLE_LEVEL  = DEF_IDLE_LEVEL
) (
    input  logic                          AROC_SS_CLK,
    input  logic                          PGD_AROC,
    input  logic [NUM_CH*BITS_PER_CH-1:0] ROC_ID,
    input  logic                          AROC_SS_LD_N,
    input  logic                          AROC_SS_DATI,
    output logic                          AROC_SS_DATO,
    output logic [NUM_CH*BITS_PER_CH-1:0] RX_DATA,
    output logic                          RX_VALID,
    output logic                          RX_HDR_OK,
    output logic                          RX_PAR_OK,
    output logic [7:0]                    FRAME_CNT
);

    localparam int          D        = NUM_CH * BITS_PER_CH;
    localparam int          F        = frame_len(HDR_W, D, PARITY_EN);
    localparam int          PAR_W    = (PARITY_EN != 0) ? 1 : 0;
    localparam int          CW       = $clog2(F + 1);
    localparam logic [31:0] HDR_BITS = 32'(HDR_VAL);

    ss_state_t        state;
    ss_state_t        state_nxt;
    logic [F-1:0]     tx_sr;
    logic [F-1:0]     tx_sr_nxt;
    logic [F-1:0]     frame_word;
    logic [D+PAR_W-1:0] body;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic             dato_nxt;
    logic [7:0]       frame_cnt_nxt;
    logic             sample_en;
    logic             frame_end;

    // Assemble {header, payload, parity} from the live straps
    generate
        if (PARITY_EN != 0) begin : g_body_par
            assign body = {ROC_ID, ^ROC_ID};
        end else begin : g_body_no_par
            assign body = ROC_ID;
        end

        if (HDR_W > 0) begin : g_frame_hdr
            assign frame_word = {HDR_BITS[HDR_W-1:0], body};
        end else begin : g_frame_no_hdr
            assign frame_word = body;
        end
    endgenerate

    // Next-state and datapath decode; cnt counts bits already driven this frame
    always_comb begin
        state_nxt     = state;
        tx_sr_nxt     = tx_sr;
        cnt_nxt       = cnt;
        dato_nxt      = IDLE_LEVEL;
        frame_cnt_nxt = FRAME_CNT;
        sample_en     = 1'b0;
        frame_end     = 1'b0;

        unique case (state)
            LOAD: begin
                tx_sr_nxt = frame_word;
                cnt_nxt   = '0;
                if (AROC_SS_LD_N) begin
                    state_nxt = SHIFT;
                    dato_nxt  = frame_word[F-1];
                    tx_sr_nxt = frame_word << 1;
                    cnt_nxt   = CW'(1);
                end
            end

            SHIFT: begin
                if (!AROC_SS_LD_N) begin
                    // Host abort: drop the partial frame without reporting it
                    state_nxt = LOAD;
                    cnt_nxt   = '0;
                end else begin
                    sample_en = 1'b1;
                    if (cnt == CW'(F)) begin
                        frame_end     = 1'b1;
                        frame_cnt_nxt = FRAME_CNT + 8'd1;
                        if (CONTINUOUS != 0) begin
                            dato_nxt  = frame_word[F-1];
                            tx_sr_nxt = frame_word << 1;
                            cnt_nxt   = CW'(1);
                        end else begin
                            state_nxt = DONE;
                            cnt_nxt   = '0;
                        end
                    end else begin
                        dato_nxt  = tx_sr[F-1];
                        tx_sr_nxt = tx_sr << 1;
                        cnt_nxt   = cnt + CW'(1);
                    end
                end
            end

            DONE: begin
                if (!AROC_SS_LD_N) begin
                    state_nxt = LOAD;
                end
            end

            default: begin
                state_nxt = LOAD;
            end
        endcase
    end

    // State, shift register, bit counter, serial output and frame counter
    always_ff @(posedge AROC_SS_CLK or negedge PGD_AROC) begin
        if (!PGD_AROC) begin
            state        <= LOAD;
            tx_sr        <= '0;
            cnt          <= '0;
            AROC_SS_DATO <= IDLE_LEVEL;
            FRAME_CNT    <= 8'd0;
        end else begin
            state        <= state_nxt;
            tx_sr        <= tx_sr_nxt;
            cnt          <= cnt_nxt;
            AROC_SS_DATO <= dato_nxt;
            FRAME_CNT    <= frame_cnt_nxt;
        end
    end

    nvme_ss_rx_check #(
        .D         (D),
        .HDR_W     (HDR_W),
        .HDR_VAL   (HDR_VAL),
        .PARITY_EN (PARITY_EN)
    ) u_rx_check (
        .clk       (AROC_SS_CLK),
        .rst_n     (PGD_AROC),
        .sample_en (sample_en),
        .frame_end (frame_end),
        .dati      (AROC_SS_DATI),
        .rx_data   (RX_DATA),
        .rx_valid  (RX_VALID),
        .rx_hdr_ok (RX_HDR_OK),
        .rx_par_ok (RX_PAR_OK)
    );

endmodule

// File: tb/tb_nvme_ss_frame_shifter.sv
// Directed bench for the framed ID/status shifter: one default instance (A)
// and one two-channel continuous instance (B) on a shared clock and reset.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_nvme_ss_frame_shifter;
    import nvme_ss_pkg::*;

    logic       clk;
    logic       rst_n;

    logic [3:0] roc_a;
    logic       ld_n_a;
    logic       dati_drv;
    logic       loopback;
    logic       dati_a;
    logic       dato_a;
    logic [3:0] rx_data_a;
    logic       rx_valid_a;
    logic       rx_hdr_ok_a;
    logic       rx_par_ok_a;
    logic [7:0] frame_cnt_a;

    logic [7:0] roc_b;
    logic       ld_n_b;
    logic       dati_b;
    logic       dato_b;
    logic [7:0] rx_data_b;
    logic       rx_valid_b;
    logic       rx_hdr_ok_b;
    logic       rx_par_ok_b;
    logic [7:0] frame_cnt_b;

    int         vectors;
    int         miscompares;
    logic [8:0]  exp9;
    logic [8:0]  rxv;
    logic [12:0] frame13;

    assign dati_a = loopback ? dato_a : dati_drv;
    assign dati_b = 1'b0;

    nvme_ss_frame_shifter dut_a (
        .AROC_SS_CLK  (clk),
        .PGD_AROC     (rst_n),
        .ROC_ID       (roc_a),
        .AROC_SS_LD_N (ld_n_a),
        .AROC_SS_DATI (dati_a),
        .AROC_SS_DATO (dato_a),
        .RX_DATA      (rx_data_a),
        .RX_VALID     (rx_valid_a),
        .RX_HDR_OK    (rx_hdr_ok_a),
        .RX_PAR_OK    (rx_par_ok_a),
        .FRAME_CNT    (frame_cnt_a)
    );

    nvme_ss_frame_shifter #(
        .NUM_CH      (2),
        .BITS_PER_CH (4),
        .CONTINUOUS  (1)
    ) dut_b (
        .AROC_SS_CLK  (clk),
        .PGD_AROC     (rst_n),
        .ROC_ID       (roc_b),
        .AROC_SS_LD_N (ld_n_b),
        .AROC_SS_DATI (dati_b),
        .AROC_SS_DATO (dato_b),
        .RX_DATA      (rx_data_b),
        .RX_VALID     (rx_valid_b),
        .RX_HDR_OK    (rx_hdr_ok_b),
        .RX_PAR_OK    (rx_par_ok_b),
        .FRAME_CNT    (frame_cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Wait for the falling edge, then drive the inputs for the next rising edge
    task automatic applyStimulus(input logic lda, input logic dina, input logic ldb);
        @(negedge clk);
        ld_n_a   = lda;
        dati_drv = dina;
        ld_n_b   = ldb;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        ld_n_a      = 1'b0;
        ld_n_b      = 1'b0;
        dati_drv    = 1'b0;
        loopback    = 1'b0;
        roc_a       = 4'b1001;
        roc_b       = 8'hA5;

        // Reset values
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);
        checkOutput("rst_dato",      32'(dato_a),      32'd0);
        checkOutput("rst_frame_cnt", 32'(frame_cnt_a), 32'd0);
        checkOutput("rst_rx_data",   32'(rx_data_a),   32'd0);
        checkOutput("rst_rx_valid",  32'(rx_valid_a),  32'd0);
        checkOutput("rst_hdr_ok",    32'(rx_hdr_ok_a), 32'd0);
        checkOutput("rst_par_ok",    32'(rx_par_ok_a), 32'd0);
        checkOutput("rst_state",     32'(dut_a.state), 32'(LOAD));
        rst_n = 1'b1;

        // Frame of 4'b1001: header 1010, payload 1001, parity 0
        repeat (5) applyStimulus(0, 0, 0);
        checkOutput("load_idle", 32'(dato_a), 32'd0);
        applyStimulus(1, 0, 0);
        exp9 = 9'b1010_1001_0;
        for (int k = 0; k < 9; k++) begin
            applyStimulus(1, 0, 0);
            checkOutput($sformatf("t1_bit%0d", k), 32'(dato_a), 32'(exp9[8-k]));
        end
        applyStimulus(1, 0, 0);
        checkOutput("t1_end_dato",      32'(dato_a),      32'd0);
        checkOutput("t1_end_rx_valid",  32'(rx_valid_a),  32'd1);
        checkOutput("t1_end_frame_cnt", 32'(frame_cnt_a), 32'd1);
        checkOutput("t1_end_rx_data",   32'(rx_data_a),   32'd0);
        checkOutput("t1_end_hdr_ok",    32'(rx_hdr_ok_a), 32'd0);
        checkOutput("t1_end_par_ok",    32'(rx_par_ok_a), 32'd1);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1, 0, 0);
            checkOutput("t1_hold_dato",      32'(dato_a),      32'd0);
            checkOutput("t1_hold_rx_valid",  32'(rx_valid_a),  32'd0);
            checkOutput("t1_hold_frame_cnt", 32'(frame_cnt_a), 32'd1);
            checkOutput("t1_hold_state",     32'(dut_a.state), 32'(DONE));
        end

        // Loopback of 4'b0111: parity bit 1, clean receive
        applyStimulus(0, 0, 0);
        roc_a    = 4'b0111;
        loopback = 1'b1;
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);
        applyStimulus(1, 0, 0);
        exp9 = 9'b1010_0111_1;
        for (int k = 0; k < 9; k++) begin
            applyStimulus(1, 0, 0);
            checkOutput($sformatf("t2_bit%0d", k), 32'(dato_a), 32'(exp9[8-k]));
            checkOutput("t2_no_valid", 32'(rx_valid_a), 32'd0);
        end
        applyStimulus(1, 0, 0);
        checkOutput("t2_rx_valid",  32'(rx_valid_a),  32'd1);
        checkOutput("t2_rx_data",   32'(rx_data_a),   32'h7);
        checkOutput("t2_hdr_ok",    32'(rx_hdr_ok_a), 32'd1);
        checkOutput("t2_par_ok",    32'(rx_par_ok_a), 32'd1);
        checkOutput("t2_frame_cnt", 32'(frame_cnt_a), 32'd2);
        applyStimulus(1, 0, 0);
        checkOutput("t2_valid_pulse", 32'(rx_valid_a), 32'd0);
        checkOutput("t2_data_hold",   32'(rx_data_a),  32'h7);

        // Bad header 1110, payload 0110 with wrong parity 1
        loopback = 1'b0;
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);
        applyStimulus(1, 0, 0);
        rxv = 9'b1110_0110_1;
        for (int k = 0; k < 9; k++) begin
            applyStimulus(1, rxv[8-k], 0);
            checkOutput($sformatf("t3_bit%0d", k), 32'(dato_a), 32'(exp9[8-k]));
        end
        applyStimulus(1, 0, 0);
        checkOutput("t3_rx_valid",  32'(rx_valid_a),  32'd1);
        checkOutput("t3_rx_data",   32'(rx_data_a),   32'h6);
        checkOutput("t3_hdr_ok",    32'(rx_hdr_ok_a), 32'd0);
        checkOutput("t3_par_ok",    32'(rx_par_ok_a), 32'd0);
        checkOutput("t3_frame_cnt", 32'(frame_cnt_a), 32'd3);

        // Abort after five bits, then a full resend from bit 0
        roc_a    = 4'b1001;
        loopback = 1'b1;
        exp9     = 9'b1010_1001_0;
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);
        applyStimulus(1, 0, 0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1, 0, 0);
            checkOutput($sformatf("t4_bit%0d", k), 32'(dato_a), 32'(exp9[8-k]));
        end
        applyStimulus(0, 0, 0);
        checkOutput("t4_bit4", 32'(dato_a), 32'(exp9[4]));
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 0, 0);
            checkOutput("t4_abort_dato",      32'(dato_a),      32'd0);
            checkOutput("t4_abort_rx_valid",  32'(rx_valid_a),  32'd0);
            checkOutput("t4_abort_frame_cnt", 32'(frame_cnt_a), 32'd3);
            checkOutput("t4_abort_rx_data",   32'(rx_data_a),   32'h6);
            checkOutput("t4_abort_hdr_ok",    32'(rx_hdr_ok_a), 32'd0);
            checkOutput("t4_abort_par_ok",    32'(rx_par_ok_a), 32'd0);
        end
        applyStimulus(1, 0, 0);
        for (int k = 0; k < 9; k++) begin
            applyStimulus(1, 0, 0);
            checkOutput($sformatf("t4_resend_bit%0d", k), 32'(dato_a), 32'(exp9[8-k]));
        end
        applyStimulus(1, 0, 0);
        checkOutput("t4_rx_valid",  32'(rx_valid_a),  32'd1);
        checkOutput("t4_rx_data",   32'(rx_data_a),   32'h9);
        checkOutput("t4_hdr_ok",    32'(rx_hdr_ok_a), 32'd1);
        checkOutput("t4_par_ok",    32'(rx_par_ok_a), 32'd1);
        checkOutput("t4_frame_cnt", 32'(frame_cnt_a), 32'd4);

        // Continuous 13-bit frames of 8'hA5 on instance B, LD_N high for 40 edges
        frame13 = 13'b1010_1010_0101_0;
        applyStimulus(1, 0, 1);
        for (int c = 0; c < 39; c++) begin
            applyStimulus(1, 0, 1);
            checkOutput($sformatf("t5_bit_c%0d", c), 32'(dato_b), 32'(frame13[12 - (c % 13)]));
            checkOutput($sformatf("t5_cnt_c%0d", c), 32'(frame_cnt_b), 32'(c / 13));
            checkOutput($sformatf("t5_valid_c%0d", c), 32'(rx_valid_b), 32'((c > 0) && (c % 13 == 0)));
            if (c == 13) begin
                checkOutput("t5_rx_data", 32'(rx_data_b),   32'd0);
                checkOutput("t5_hdr_ok",  32'(rx_hdr_ok_b), 32'd0);
                checkOutput("t5_par_ok",  32'(rx_par_ok_b), 32'd1);
            end
        end
        applyStimulus(1, 0, 0);
        checkOutput("t5_last_bit",   32'(dato_b),      32'(frame13[12]));
        checkOutput("t5_frame_cnt",  32'(frame_cnt_b), 32'd3);
        checkOutput("t5_last_valid", 32'(rx_valid_b),  32'd1);
        applyStimulus(1, 0, 0);
        checkOutput("t5_abort_dato", 32'(dato_b),      32'd0);
        checkOutput("t5_abort_cnt",  32'(frame_cnt_b), 32'd3);
        checkOutput("t5_abort_vld",  32'(rx_valid_b),  32'd0);

        // Power-good drop in the middle of a frame
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);
        applyStimulus(1, 0, 0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1, 0, 0);
            checkOutput($sformatf("t6_bit%0d", k), 32'(dato_a), 32'(exp9[8-k]));
        end
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_dato",        32'(dato_a),      32'd0);
        checkOutput("t6_frame_cnt",   32'(frame_cnt_a), 32'd0);
        checkOutput("t6_rx_data",     32'(rx_data_a),   32'd0);
        checkOutput("t6_rx_valid",    32'(rx_valid_a),  32'd0);
        checkOutput("t6_hdr_ok",      32'(rx_hdr_ok_a), 32'd0);
        checkOutput("t6_par_ok",      32'(rx_par_ok_a), 32'd0);
        checkOutput("t6_frame_cnt_b", 32'(frame_cnt_b), 32'd0);
        applyStimulus(0, 0, 0);
        rst_n = 1'b1;
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);
        checkOutput("t6_post_dato",  32'(dato_a),      32'd0);
        checkOutput("t6_post_state", 32'(dut_a.state), 32'(LOAD));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
